// File: rtl/logit_sequencer.sv
// logit_sequencer: time-multiplexes one XNOR-popcount datapath over all
// neurons of a binary fully-connected output layer and streams signed
// logits over a valid/ready handshake.
// Optional feature macro: LOGIT_ARGMAX_EN (running argmax drives class_idx).
module logit_sequencer #(
   parameter int IN_WIDTH = 256,
   parameter int CHUNK    = 32,
   parameter int NEURONS  = 10,
   localparam int CHUNKS  = IN_WIDTH / CHUNK,
   localparam int AW      = $clog2(NEURONS * CHUNKS),
   localparam int PW      = $clog2(IN_WIDTH + 1),
   localparam int LW      = PW + 2,
   localparam int IW      = $clog2(NEURONS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [IN_WIDTH-1:0]  act_in,
   output logic                 busy,
   output logic                 w_en,
   output logic [AW-1:0]        w_addr,
   input  logic [CHUNK-1:0]     w_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [LW-1:0] out_logit,
   output logic [IW-1:0]        out_idx,
   output logic                 done,
   output logic [IW-1:0]        class_idx
);

   localparam int CW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int CPW = $clog2(CHUNK + 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT, S_FIN} state_t;

   state_t               state_reg, state_next;
   logic [IN_WIDTH-1:0]  act_reg;
   logic [CW-1:0]        chunk_reg;
   logic [CW-1:0]        rd_chunk_reg;
   logic                 rd_pend_reg;
   logic [PW-1:0]        acc_reg;
   logic [IW-1:0]        neuron_reg;
   logic [AW-1:0]        w_addr_reg;

   logic [CHUNK-1:0]     act_chunks [CHUNKS];
   logic [CHUNK-1:0]     act_chunk;
   logic [CHUNK-1:0]     match;
   logic [CPW-1:0]       pop;
   logic signed [LW-1:0] logit_val;
   logic                 last;
   logic                 accept;

   // Slice the latched activations so the chunk that pairs with the
   // returning ROM word can be picked by a plain array index.
   genvar gi;
   generate
      for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
         assign act_chunks[gi] = act_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   assign last      = (neuron_reg == IW'(NEURONS - 1));
   assign accept    = (state_reg == S_EMIT) && out_ready;
   assign logit_val = $signed({1'b0, acc_reg, 1'b0}) - $signed(LW'(IN_WIDTH));

   assign busy      = (state_reg != S_IDLE);
   assign w_en      = (state_reg == S_RUN);
   assign w_addr    = w_addr_reg;
   assign out_valid = (state_reg == S_EMIT);
   assign out_logit = out_valid ? logit_val : '0;
   assign out_idx   = neuron_reg;
   assign done      = (state_reg == S_FIN);

   // XNOR-popcount of the activation chunk against the ROM word read last cycle
   always_comb begin
      act_chunk = act_chunks[rd_chunk_reg];
      match     = ~(act_chunk ^ w_data);
      pop       = '0;
      for (int i = 0; i < CHUNK; i++) begin
         pop = pop + CPW'(match[i]);
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (chunk_reg == CW'(CHUNKS - 1)) state_next = S_DRAIN;
         S_DRAIN: state_next = S_EMIT;
         S_EMIT:  if (out_ready) state_next = last ? S_FIN : S_RUN;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register and datapath: address/chunk counters, accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         act_reg      <= '0;
         chunk_reg    <= '0;
         rd_chunk_reg <= '0;
         rd_pend_reg  <= 1'b0;
         acc_reg      <= '0;
         neuron_reg   <= '0;
         w_addr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         // ROM data returns one cycle after each read; remember which chunk it is
         rd_pend_reg  <= (state_reg == S_RUN);
         rd_chunk_reg <= chunk_reg;
         if (rd_pend_reg) begin
            acc_reg <= acc_reg + PW'(pop);
         end
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  act_reg    <= act_in;
                  w_addr_reg <= '0;
                  neuron_reg <= '0;
                  chunk_reg  <= '0;
                  acc_reg    <= '0;
               end
            end
            S_RUN: begin
               w_addr_reg <= w_addr_reg + AW'(1);
               chunk_reg  <= (chunk_reg == CW'(CHUNKS - 1)) ? '0 : chunk_reg + CW'(1);
            end
            S_EMIT: begin
               if (out_ready) begin
                  // clearing here means the next RUN starts from zero
                  acc_reg    <= '0;
                  neuron_reg <= last ? '0 : neuron_reg + IW'(1);
               end
            end
            S_FIN: begin
               w_addr_reg <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef LOGIT_ARGMAX_EN
   logic signed [LW-1:0] max_reg;
   logic [IW-1:0]        max_idx_reg;
   logic [IW-1:0]        class_reg;
   logic                 max_valid_reg;
   logic                 take;

   // strict greater-than keeps the lower index on ties
   assign take = !max_valid_reg || (logit_val > max_reg);

   // Running argmax over accepted logits; result registered on the last one
   always_ff @(posedge clk) begin
      if (rst) begin
         max_reg       <= '0;
         max_idx_reg   <= '0;
         class_reg     <= '0;
         max_valid_reg <= 1'b0;
      end else if (state_reg == S_IDLE && start) begin
         max_valid_reg <= 1'b0;
      end else if (accept) begin
         max_valid_reg <= 1'b1;
         if (take) begin
            max_reg     <= logit_val;
            max_idx_reg <= neuron_reg;
         end
         if (last) begin
            class_reg <= take ? neuron_reg : max_idx_reg;
         end
      end
   end

   assign class_idx = class_reg;
`else
   assign class_idx = '0;
`endif

endmodule

// File: tb/tb_logit_sequencer.sv
// Directed self-checking bench for logit_sequencer (default parameters).
module tb_logit_sequencer;
   localparam int IN_WIDTH = 256;
   localparam int CHUNK    = 32;
   localparam int NEURONS  = 10;
   localparam int CHUNKS   = 8;
   localparam int NADDR    = 80;
   localparam int AW       = 7;
   localparam int LW       = 11;
   localparam int IW       = 4;
`ifdef LOGIT_ARGMAX_EN
   localparam bit ARGMAX = 1'b1;
`else
   localparam bit ARGMAX = 1'b0;
`endif

   logic                 clk, rst, start, busy, w_en, out_valid, out_ready, done;
   logic [IN_WIDTH-1:0]  act_in;
   logic [AW-1:0]        w_addr;
   logic [CHUNK-1:0]     w_data;
   logic signed [LW-1:0] out_logit;
   logic [IW-1:0]        out_idx, class_idx;

   logic [CHUNK-1:0]     rom [NADDR];
   int                   rd_cnt [NADDR];
   logic signed [LW-1:0] exp_l [NEURONS];
   int total = 0;
   int bad   = 0;

   logit_sequencer #(.IN_WIDTH(IN_WIDTH), .CHUNK(CHUNK), .NEURONS(NEURONS)) dut (
      .clk(clk), .rst(rst), .start(start), .act_in(act_in), .busy(busy),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_logit(out_logit), .out_idx(out_idx),
      .done(done), .class_idx(class_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous ROM model plus per-address read counter
   always @(posedge clk) begin
      if (w_en) begin
         w_data <= rom[w_addr];
         rd_cnt[w_addr]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_const(input logic [CHUNK-1:0] v);
      for (int a = 0; a < NADDR; a++) rom[a] = v;
   endtask

   // neuron k holds 16*k ones packed into the low bits of its 256-bit row
   task automatic load_ramp();
      logic [IN_WIDTH-1:0] vec;
      for (int k = 0; k < NEURONS; k++) begin
         vec = '0;
         for (int b = 0; b < 16 * k; b++) vec[b] = 1'b1;
         for (int j = 0; j < CHUNKS; j++) rom[k*CHUNKS + j] = vec[j*CHUNK +: CHUNK];
      end
   endtask

   // One inference: start pulsed in cycle 0, cycles counted from there
   task automatic run_seq(input string name, input int stall, input bit restart,
                          input bit clr_act, input int exp_class);
      int cyc, hs, first_v, done_cyc, done_n, stall_left, limit;
      logic signed [LW-1:0] held_l;
      logic [IW-1:0] held_i;
      cyc = 0; hs = 0; first_v = -1; done_cyc = -1; done_n = 0; stall_left = stall;
      held_l = '0; held_i = '0;
      limit = NEURONS * (CHUNKS + 2) + stall + 10;
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      cyc = 1;
      start = 1'b0;
      if (clr_act) act_in = '0;
      while (cyc < limit) begin
         start = restart && (cyc == 3);
         out_ready = 1'b1;
         if (out_valid && first_v < 0) first_v = cyc;
         if (out_valid && hs == 0 && stall_left > 0) begin
            out_ready = 1'b0;
            if (stall_left == stall) begin
               held_l = out_logit;
               held_i = out_idx;
            end else begin
               check({name, "_stall_logit"}, 32'(out_logit), 32'(held_l));
               check({name, "_stall_idx"}, 32'(out_idx), 32'(held_i));
               check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
            end
            check({name, "_stall_wen"}, 32'(w_en), 32'd0);
            stall_left--;
         end
         if (out_valid && out_ready) begin
            $display("%s hs %0d cycle %0d idx=%0d logit=%0d", name, hs, cyc, out_idx, out_logit);
            if (hs < NEURONS) begin
               check({name, "_logit"}, 32'(out_logit), 32'(exp_l[hs]));
               check({name, "_idx"}, 32'(out_idx), 32'(hs));
            end
            hs++;
         end
         if (done) begin
            if (done_n == 0) done_cyc = cyc;
            done_n++;
         end
         tick();
         cyc++;
      end
      check({name, "_handshakes"}, 32'(hs), 32'(NEURONS));
      check({name, "_first_valid"}, 32'(first_v), 32'(CHUNKS + 2));
      check({name, "_done_cycle"}, 32'(done_cyc), 32'(NEURONS * (CHUNKS + 2) + 1 + stall));
      check({name, "_done_count"}, 32'(done_n), 32'd1);
      check({name, "_class"}, 32'(class_idx), ARGMAX ? 32'(exp_class) : 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
      check({name, "_idx_wrap"}, 32'(out_idx), 32'd0);
   endtask

   initial begin
      int cyc, odd, seen;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1; act_in = '1;
      load_const('0);
      for (int a = 0; a < NADDR; a++) rd_cnt[a] = 0;
      repeat (3) tick();

      // reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wen", 32'(w_en), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_waddr", 32'(w_addr), 32'd0);
      check("rst_logit", 32'(out_logit), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_class", 32'(class_idx), 32'd0);
      rst = 1'b0;
      tick();

      // all ones against all ones: full agreement
      load_const('1); act_in = '1;
      for (int k = 0; k < NEURONS; k++) exp_l[k] = 11'sd256;
      run_seq("ones", 0, 1'b0, 1'b0, 0);

      // all ones against all zeros: full disagreement, -256 = 0x700
      load_const('0); act_in = '1;
      for (int k = 0; k < NEURONS; k++) exp_l[k] = 11'h700;
      run_seq("zeros", 0, 1'b0, 1'b0, 0);

      // zeros against zeros: XNOR agrees everywhere
      load_const('0); act_in = '0;
      for (int k = 0; k < NEURONS; k++) exp_l[k] = 11'sd256;
      run_seq("xnor00", 0, 1'b0, 1'b0, 0);

      // ramp: logit 32k-256
      load_ramp(); act_in = '1;
      for (int k = 0; k < NEURONS; k++) exp_l[k] = LW'(32 * k - 256);
      run_seq("ramp", 0, 1'b0, 1'b0, 9);

      // ramp with 5-cycle stall at the first EMIT
      run_seq("stall", 5, 1'b0, 1'b0, 9);

      // chunk pairing: low half active; k<=8 -> 32k, k=9 -> 224
      act_in = '0;
      act_in[IN_WIDTH/2-1:0] = '1;
      for (int k = 0; k < NEURONS; k++) exp_l[k] = (k < 9) ? LW'(32 * k) : 11'sd224;
      run_seq("pairing", 0, 1'b0, 1'b0, 8);

      // reset during RUN of neuron 3 (cycles 31..38)
      act_in = '1;
      for (int k = 0; k < NEURONS; k++) exp_l[k] = LW'(32 * k - 256);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (cyc < 33) begin
         tick();
         cyc++;
      end
      check("midrst_wen_before", 32'(w_en), 32'd1);
      check("midrst_addr_before", 32'(w_addr), 32'd26);
      rst = 1'b1;
      tick();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_wen", 32'(w_en), 32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid || done) seen++;
         tick();
      end
      check("midrst_quiet", 32'(seen), 32'd0);
      run_seq("after_rst", 0, 1'b0, 1'b0, 9);

      // start pulsed while busy and act_in cleared after acceptance: both ignored
      for (int a = 0; a < NADDR; a++) rd_cnt[a] = 0;
      act_in = '1;
      run_seq("restart", 0, 1'b1, 1'b1, 9);
      odd = 0;
      for (int a = 0; a < NADDR; a++) if (rd_cnt[a] != 1) odd++;
      check("restart_addr_cover", 32'(odd), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
